// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM states, frame constants, default width).
// Latency: n/a (package). Backpressure: n/a.
// Used by the transmit path (uart_tx, uart_tx_parity_calc) and the receive path.
//
// Contents:
//   DEFAULT_DATA_WIDTH  default payload bits per frame
//   START_BIT/STOP_BIT  line levels of the framing bits
//   uart_state_e        transmit/receive FSM state encoding
//   uart_cnt_width()    bit-counter width for a given payload width

package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Line levels. The idle line also sits at STOP_BIT.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // ST_PARITY is only entered when parity support is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // clog2(width), but never zero so a 1-bit payload still gets a legal counter.
  function automatic int uart_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: parity bit for one UART payload.
// Latency: combinational. Backpressure: none.
// Only instantiated when UART_TX_PARITY_EN is defined.
//
// Ports:
//   data     payload whose bits are covered by the parity bit
//   par_typ  0 = even parity, 1 = odd parity
//   par_bit  bit to place on the line after the last data bit

module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones (data + parity) even, so the
  // parity bit is the XOR of the data. Odd parity is simply its complement.
  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one parallel payload per frame: start, data LSB first, optional parity, stop.
// Latency: frame start bit appears on tx_out the cycle after acceptance; one line bit per CLK.
// Backpressure: busy high while a frame is on the line; data_valid only accepted in IDLE or STOP.
//
// Build option: define UART_TX_PARITY_EN to compile in the parity bit. Without it
// every frame is start + DATA_WIDTH data + stop, and par_en/par_typ are ignored.
//
// Ports:
//   CLK         clock; one serial bit per cycle
//   RST         synchronous active-high reset
//   p_data      payload, captured only on the accepting edge
//   data_valid  request to send p_data
//   par_en      append a parity bit (captured on the accepting edge)
//   par_typ     0 = even, 1 = odd parity (captured on the accepting edge)
//   tx_out      registered serial line, idle high
//   busy        registered, high for every cycle of a frame

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = uart_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bit;
`else
  // Parity inputs have no function in this build.
  logic                  unused_par_inputs;
  assign unused_par_inputs = par_en ^ par_typ;
`endif

  // A new frame can be taken while idle, or during the stop bit so that frames
  // run back to back with no idle gap.
  logic accept;
  assign accept = data_valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

`ifdef UART_TX_PARITY_EN
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );
`endif

  // ---------------------------------------------------------------------------
  // State register. Reset wins over everything, including a same-edge request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      tx_out_q  <= STOP_BIT;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Frame settings are only loaded on acceptance, so requests
  // arriving mid-frame cannot disturb the frame already on the line.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`endif

    case (state_q)
      ST_IDLE, ST_STOP: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d   = ST_START;
          data_d    = p_data;
`ifdef UART_TX_PARITY_EN
          par_en_d  = par_en;
          par_typ_d = par_typ;
`endif
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end

      ST_DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Outputs are decoded from the *next* state and registered, so
  // tx_out/busy line up cycle-for-cycle with state_q and leave no comb path
  // from the inputs to the pins.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_out_d = STOP_BIT;
    busy_d   = 1'b1;

    case (state_d)
      ST_IDLE: begin
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
      end

      ST_START: begin
        tx_out_d = START_BIT;
      end

      // cnt_d is the index of the bit going onto the line this cycle.
      ST_DATA: begin
        tx_out_d = data_d[cnt_d];
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_out_d = par_bit;
      end
`endif

      ST_STOP: begin
        tx_out_d = STOP_BIT;
      end

      default: begin
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int W = 8;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;

  uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // One expected frame: accepted at edge a, bit i of 'bits' is on the line
  // during the cycle following edge a+i, for len cycles.
  typedef struct {
    int          a;
    int          len;
    logic [15:0] bits;
  } frame_t;

  frame_t sb[$];
  int     checks    = 0;
  int     errors    = 0;
  int     edge_cnt  = 0;
  logic   rst_at_edge = 1'b0;
  int     next_free = 0;   // first edge at which a request would be accepted

  task automatic check(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference frame from the framing rules: start, data LSB first,
  // optional parity (ones-count of data, inverted for odd), stop.
  function automatic frame_t model_frame(input int a, input logic [W-1:0] d,
                                         input logic pe, input logic pt);
    frame_t f;
    int     ones;
    f.a    = a;
    f.bits = '0;
    f.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      f.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    f.len = W + 2;
    if (HAS_PAR && pe) begin
      f.bits[W + 1] = ((ones % 2) == 1) ^ pt;
      f.len = W + 3;
    end
    f.bits[f.len - 1] = 1'b1;
    return f;
  endfunction

  // Edge counter and reset tracker.
  initial begin
    forever begin
      @(posedge CLK);
      edge_cnt++;
      rst_at_edge = RST;
    end
  end

  // Monitor: every cycle the line and busy must match whichever frame the
  // scoreboard says is active, or the idle state.
  initial begin : monitor
    frame_t cur;
    logic   cur_act;
    logic   etx;
    logic   ebusy;
    int     e;
    cur_act = 1'b0;
    forever begin
      @(negedge CLK);
      e = edge_cnt;
      if (e >= 1) begin
        if (rst_at_edge) begin
          cur_act = 1'b0;
          etx     = 1'b1;
          ebusy   = 1'b0;
        end else begin
          if (sb.size() > 0 && sb[0].a == e) begin
            cur     = sb.pop_front();
            cur_act = 1'b1;
          end
          if (cur_act && (e - cur.a) < cur.len) begin
            etx   = cur.bits[e - cur.a];
            ebusy = 1'b1;
          end else begin
            cur_act = 1'b0;
            etx     = 1'b1;
            ebusy   = 1'b0;
          end
        end
        check("tx_out", e, tx_out, etx);
        check("busy", e, busy, ebusy);
      end
    end
  end

  // Advance to the next negedge with no request.
  task automatic tick();
    @(negedge CLK);
    RST        = 1'b0;
    data_valid = 1'b0;
  endtask

  // Drive a request for the coming edge (call right after a negedge). If the
  // model says it will be accepted, the expected frame is queued. lit_len > 0
  // selects a hand-written expected sequence (first transmitted bit is MSB).
  task automatic drive(input logic [W-1:0] d, input logic pe, input logic pt,
                       input logic [15:0] lit, input int lit_len);
    int     e;
    frame_t f;
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    e = edge_cnt + 1;
    if (e >= next_free) begin
      if (lit_len > 0) begin
        f.a    = e;
        f.len  = lit_len;
        f.bits = '0;
        for (int i = 0; i < lit_len; i++) f.bits[i] = lit[lit_len - 1 - i];
      end else begin
        f = model_frame(e, d, pe, pt);
      end
      sb.push_back(f);
      next_free = e + f.len;
    end
  endtask

  // Wait until a request would be accepted, then issue it.
  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                      input logic [15:0] lit, input int lit_len);
    tick();
    while (edge_cnt + 1 < next_free) tick();
    drive(d, pe, pt, lit, lit_len);
  endtask

  task automatic wait_idle(input int gap);
    while (edge_cnt + 1 < next_free + gap) tick();
  endtask

  // Reset on the coming edge with a simultaneous request that must be ignored.
  task automatic do_reset();
    tick();
    RST        = 1'b1;
    data_valid = 1'b1;
    p_data     = W'($urandom);
    next_free  = edge_cnt + 2;
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    RST        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (3) @(negedge CLK);

    // Directed frames with hand-derived line sequences.
    send(8'hA5, 1'b1, 1'b0, HAS_PAR ? 16'b01010010101 : 16'b0101001011, HAS_PAR ? 11 : 10);
    wait_idle(2);
    send(8'hB8, 1'b1, 1'b1, HAS_PAR ? 16'b00001110111 : 16'b0000111011, HAS_PAR ? 11 : 10);
    wait_idle(2);
    send(8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);

    // Back-to-back: the next request lands exactly on the stop bit.
    send(8'h55, 1'b1, 1'b0, 16'h0, 0);
    send(8'h0F, 1'b0, 1'b1, 16'h0, 0);
    wait_idle(2);

    // Requests mid-frame must be ignored.
    send(8'h5A, 1'b1, 1'b1, 16'h0, 0);
    repeat (3) tick();
    drive(8'hFF, 1'b0, 1'b0, 16'h0, 0);
    tick();
    drive(8'h00, 1'b1, 1'b0, 16'h0, 0);
    wait_idle(2);

    // Reset during the 4th data bit, then a clean frame.
    send(8'h96, 1'b1, 1'b0, 16'h0, 0);
    repeat (4) tick();
    do_reset();
    tick();
    tick();
    send(8'hC3, 1'b1, 1'b1, 16'h0, 0);
    wait_idle(2);

    // Random traffic: requests at arbitrary times (some ignored, some
    // back-to-back), random parity settings, occasional resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 45) begin
        tick();
        drive(W'($urandom), 1'($urandom), 1'($urandom), 16'h0, 0);
      end else begin
        tick();
      end
    end
    wait_idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
